// File: rtl/spi_cmd_receiver.sv
// spi_cmd_receiver: arms on a key match, shifts in one SPI mode-0 command (address + data bytes), emits a write strobe; define SPI_CMD_PARITY_EN to require a trailing XOR check byte
module spi_cmd_receiver #(
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  input  logic                    sclk,
  input  logic                    match,
  output logic                    wr_en,
  output logic [7:0]              wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    err
);
`ifdef SPI_CMD_PARITY_EN
  localparam int TOTAL = DATA_BYTES + 2;
`else
  localparam int TOTAL = DATA_BYTES + 1;
`endif
  localparam int BW = $clog2(TOTAL + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(TOTAL - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t                  state_q;
  logic                    sclk_q;
  logic [2:0]              bit_cnt_q;
  logic [BW-1:0]           byte_cnt_q;
  logic [6:0]              shift_q;
  logic [8*(TOTAL-1)-1:0]  buf_q;
  logic [TW-1:0]           tmo_q;
  logic                    wr_en_q;
  logic                    busy_q;
  logic                    err_q;
  logic [7:0]              wr_addr_q;
  logic [8*DATA_BYTES-1:0] wr_data_q;
  logic                    rise;
  logic                    last_bit;
  logic                    check_ok;
  logic [7:0]              byte_d;
  logic [8*TOTAL-1:0]      cmd_d;
`ifdef SPI_CMD_PARITY_EN
  logic [7:0]              chk_d;
`endif
  // Edge detect and the whole command as it looks once the current bit lands
  always_comb begin
    rise     = sclk & ~sclk_q;
    byte_d   = {shift_q, sin};
    cmd_d    = {buf_q, byte_d};
    last_bit = (bit_cnt_q == 3'd7) && (byte_cnt_q == LAST_BYTE);
`ifdef SPI_CMD_PARITY_EN
    chk_d = '0;
    for (int i = 1; i < TOTAL; i++) chk_d ^= cmd_d[8*i +: 8];
    check_ok = chk_d == cmd_d[7:0];
`else
    check_ok = 1'b1;
`endif
  end
  // Receive FSM: match (re)arms, each sclk rise shifts a bit, last bit strobes or flags, idle too long aborts
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sclk_q  <= sclk;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      if (match) begin
        state_q    <= ARMED;
        busy_q     <= 1'b1;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        shift_q    <= '0;
        buf_q      <= '0;
        tmo_q      <= '0;
      end else if (state_q == ARMED) begin
        if (rise) begin
          tmo_q     <= '0;
          shift_q   <= byte_d[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_q <= byte_cnt_q + BW'(1);
            buf_q      <= cmd_d[8*(TOTAL-1)-1:0];
          end
          if (last_bit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            wr_en_q <= check_ok;
            err_q   <= ~check_ok;
            if (check_ok) begin
              wr_addr_q <= cmd_d[8*TOTAL-1 -: 8];
              wr_data_q <= cmd_d[8*TOTAL-9 -: 8*DATA_BYTES];
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign err     = err_q;
endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb_spi_cmd_receiver: directed and randomized SPI commands checked every cycle against a bit-queue model
module tb_spi_cmd_receiver;
  localparam int DB  = 2;
  localparam int TMO = 1024;
`ifdef SPI_CMD_PARITY_EN
  localparam int TOT = DB + 2;
`else
  localparam int TOT = DB + 1;
`endif
  logic clk = 0, rst = 0, sin = 0, sclk = 0, match = 0;
  logic wr_en, busy, err;
  logic [7:0] wr_addr;
  logic [8*DB-1:0] wr_data;
  int checks = 0, passes = 0, cyc = 0;
  int wr_cnt = 0, err_cnt = 0, wr_cyc = -1, err_cyc = -1, rise_cyc = 0;
  int c0, e0;

  spi_cmd_receiver #(.DATA_BYTES(DB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sclk(sclk), .match(match),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: collect received bits in a queue, decode a full command by bytes
  bit m_armed, m_prev, m_wr, m_err, m_r;
  logic [7:0] m_addr, m_x;
  logic [7:0] m_b[TOT];
  logic [8*DB-1:0] m_data, m_d;
  int m_idle;
  bit m_bits[$];

  always @(posedge clk) begin
    cyc++;
    m_wr = 0;
    m_err = 0;
    if (!rst) begin
      m_armed = 0; m_prev = 0; m_addr = 0; m_data = 0; m_idle = 0;
      m_bits.delete();
    end else begin
      m_r = sclk && !m_prev;
      m_prev = sclk;
      if (match) begin
        m_armed = 1; m_idle = 0;
        m_bits.delete();
      end else if (m_armed && m_r) begin
        m_bits.push_back(sin);
        m_idle = 0;
        if (m_bits.size() == 8 * TOT) begin
          for (int k = 0; k < TOT; k++) begin
            m_b[k] = 0;
            for (int j = 0; j < 8; j++) m_b[k] = {m_b[k][6:0], m_bits[8*k+j]};
          end
          m_x = 0;
          for (int k = 0; k < TOT - 1; k++) m_x ^= m_b[k];
          m_armed = 0;
`ifdef SPI_CMD_PARITY_EN
          if (m_x != m_b[TOT-1]) m_err = 1;
          else begin
`else
          begin
`endif
            m_wr = 1;
            m_addr = m_b[0];
            m_d = 0;
            for (int k = 1; k <= DB; k++) m_d = (m_d << 8) | (8*DB)'(m_b[k]);
            m_data = m_d;
          end
        end
      end else if (m_armed) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1;
          m_armed = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) if (cyc > 0) begin
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, err} === {m_wr, m_addr, m_data, m_armed, m_err}) passes++;
    else $display("FAIL cycle %0d outputs wr_en/addr/data/busy/err got %b/%h/%h/%b/%b want %b/%h/%h/%b/%b",
                  cyc, wr_en, wr_addr, wr_data, busy, err, m_wr, m_addr, m_data, m_armed, m_err);
    if (wr_en) begin wr_cnt++; wr_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // rise_cyc is the clk edge index that first samples sclk high
  task automatic send_bit(bit b, bit with_match = 0);
    sin = b; sclk = 0;
    tick(5);
    sclk = 1; match = with_match; rise_cyc = cyc + 1;
    tick(1);
    match = 0;
    tick(4);
  endtask

  task automatic send_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_match();
    match = 1;
    tick(1);
    match = 0;
  endtask

  initial begin
    tick(3);
    rst = 1;
    tick(2);
    chk("reset outputs", {wr_en, wr_addr, wr_data, busy, err}, 0);
    // Basic command
    c0 = wr_cnt;
    pulse_match();
    chk("busy after match", busy, 1);
    send_byte(8'h05); send_byte(8'hA5); send_byte(8'h3C);
`ifdef SPI_CMD_PARITY_EN
    send_byte(8'h9C);
`endif
    tick(3);
    chk("single wr_en", wr_cnt, c0 + 1);
    chk("wr_en one clk after final rise", wr_cyc, rise_cyc);
    chk("wr_addr basic", wr_addr, 8'h05);
    chk("wr_data basic", wr_data, 16'hA53C);
    chk("busy cleared", busy, 0);
    // No key, no write
    c0 = wr_cnt;
    send_byte(8'h05); send_byte(8'hA5); send_byte(8'h3C);
    tick(3);
    chk("no key no wr_en", wr_cnt, c0);
    chk("no key busy", busy, 0);
    // Timeout
    c0 = wr_cnt; e0 = err_cnt;
    pulse_match();
    send_byte(8'h05);
    tick(2000);
    chk("timeout err once", err_cnt, e0 + 1);
    chk("timeout latency", err_cyc, rise_cyc + TMO);
    chk("timeout no wr_en", wr_cnt, c0);
    chk("timeout busy", busy, 0);
    chk("timeout addr held", wr_addr, 8'h05);
    chk("timeout data held", wr_data, 16'hA53C);
    // Reset mid-command
    c0 = wr_cnt; e0 = err_cnt;
    pulse_match();
    send_byte(8'h05);
    rst = 0;
    tick(2);
    rst = 1;
    send_byte(8'hA5); send_byte(8'h3C);
    tick(3);
    chk("reset mid no wr_en", wr_cnt, c0);
    chk("reset mid no err", err_cnt, e0);
    chk("reset mid outputs zero", {wr_en, wr_addr, wr_data, busy, err}, 0);
    // Re-arm restarts reception
    c0 = wr_cnt;
    pulse_match();
    send_byte(8'h01);
    pulse_match();
    send_byte(8'h07); send_byte(8'h12); send_byte(8'h34);
`ifdef SPI_CMD_PARITY_EN
    send_byte(8'h21);
`endif
    tick(3);
    chk("restart single wr_en", wr_cnt, c0 + 1);
    chk("restart addr", wr_addr, 8'h07);
    chk("restart data", wr_data, 16'h1234);
`ifdef SPI_CMD_PARITY_EN
    c0 = wr_cnt; e0 = err_cnt;
    pulse_match();
    send_byte(8'h05); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h9D);
    tick(3);
    chk("bad check err", err_cnt, e0 + 1);
    chk("bad check no wr_en", wr_cnt, c0);
    chk("bad check addr held", wr_addr, 8'h07);
`endif
    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      int op, n;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        if (op == 5) begin
          send_bit(1'($urandom), 1);
          for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        end else pulse_match();
        n = ($urandom_range(0, 1) == 1) ? TOT : $urandom_range(0, TOT + 1);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
      end else if (op == 6) begin
        tick($urandom_range(1000, 1100));
      end else if (op == 7) begin
        rst = 0;
        tick($urandom_range(1, 2));
        rst = 1;
      end else begin
        n = $urandom_range(1, TOT);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
      end
      tick($urandom_range(1, 20));
    end
    tick(5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
